// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-serial RAM arbiter: FSM states, access sizes,
// port owner and the request fields latched on grant.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_e;

    // Counter must reach n (=4) on reads, hence three bits.
    localparam int CNT_W = 3;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        owner_e      owner;
        logic        we;
        cnt_t        n;
        logic [31:0] wdata;
    } xfer_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response signals and the byte-wide RAM port.
// slave = the arbiter, master = requesters plus the RAM.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic                  if_done;
    logic [31:0]           if_data;
    logic                  if_stall_req;

    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_size;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_done;
    logic [31:0]           mem_rdata;
    logic                  mem_stall_req;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_wr;
    logic [7:0]            ram_dout;
    logic [7:0]            ram_din;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_done, if_data, if_stall_req,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        output mem_done, mem_rdata, mem_stall_req,
        output ram_addr, ram_wr, ram_dout,
        input  ram_din
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_done, if_data, if_stall_req,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
        input  mem_done, mem_rdata, mem_stall_req,
        input  ram_addr, ram_wr, ram_dout,
        output ram_din
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 1/2/4-byte accesses and assembling read data little-endian.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus_if
);

    arb_state_e            state_q, state_d;
    xfer_t                 ctl_q, ctl_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    cnt_t                  cnt_q, cnt_d;
    logic [31:0]           data_q, data_d;

    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic                  ram_wr_q, ram_wr_d;
    logic [7:0]            ram_dout_q, ram_dout_d;
    logic                  if_done_q, if_done_d;
    logic                  mem_done_q, mem_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic [31:0]           mem_rdata_q, mem_rdata_d;

    logic                  gnt_valid;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    xfer_t                 gnt_xfer;
    logic                  enter_done;
    cnt_t                  cnt_next;
    cnt_t                  cnt_prev;

    function automatic cnt_t size_to_bytes(input logic [1:0] size);
        case (size)
            MEM_BYTE: return cnt_t'(1);
            MEM_HALF: return cnt_t'(2);
            default:  return cnt_t'(4);
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    assign cnt_next = cnt_q + cnt_t'(1);
    assign cnt_prev = cnt_q - cnt_t'(1);

    // MEM wins a simultaneous request; a fetch is always four bytes.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_addr  = '0;
        gnt_xfer  = '0;
        if (bus_if.mem_req) begin
            gnt_valid      = 1'b1;
            gnt_addr       = bus_if.mem_addr;
            gnt_xfer.owner = OWNER_MEM;
            gnt_xfer.we    = bus_if.mem_we;
            gnt_xfer.n     = size_to_bytes(bus_if.mem_size);
            gnt_xfer.wdata = bus_if.mem_wdata;
        end else if (bus_if.if_req) begin
            gnt_valid      = 1'b1;
            gnt_addr       = bus_if.if_addr;
            gnt_xfer.owner = OWNER_IF;
            gnt_xfer.we    = 1'b0;
            gnt_xfer.n     = cnt_t'(4);
            gnt_xfer.wdata = '0;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        ctl_d       = ctl_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        ram_addr_d  = ram_addr_q;
        ram_wr_d    = 1'b0;
        ram_dout_d  = ram_dout_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        enter_done  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_d    = ARB_ACCESS;
                    ctl_d      = gnt_xfer;
                    base_d     = gnt_addr;
                    cnt_d      = '0;
                    data_d     = '0;
                    ram_addr_d = gnt_addr;
                    ram_wr_d   = gnt_xfer.we;
                    ram_dout_d = gnt_xfer.wdata[7:0];
                end
            end

            ARB_ACCESS: begin
                if (ctl_q.owner == OWNER_IF && bus_if.if_flush) begin
                    state_d = ARB_IDLE;
                    cnt_d   = '0;
                end else if (ctl_q.we) begin
                    // The registered outputs already carry byte cnt_q this cycle.
                    if (cnt_q == ctl_q.n - cnt_t'(1)) begin
                        enter_done = 1'b1;
                    end else begin
                        cnt_d      = cnt_next;
                        ram_addr_d = base_q + ADDR_WIDTH'(cnt_next);
                        ram_wr_d   = 1'b1;
                        ram_dout_d = byte_of(ctl_q.wdata, cnt_next[1:0]);
                    end
                end else begin
                    // ram_din lags its address by one cycle.
                    if (cnt_q != '0) begin
                        data_d = set_byte(data_q, cnt_prev[1:0], bus_if.ram_din);
                    end
                    if (cnt_q == ctl_q.n) begin
                        enter_done = 1'b1;
                    end else begin
                        cnt_d = cnt_next;
                        if (cnt_next < ctl_q.n) begin
                            ram_addr_d = base_q + ADDR_WIDTH'(cnt_next);
                        end
                    end
                end

                if (enter_done) begin
                    state_d = ARB_DONE;
                    if (ctl_q.owner == OWNER_IF) begin
                        if_done_d = 1'b1;
                        if_data_d = data_d;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = data_d;
                    end
                end
            end

            ARB_DONE: state_d = ARB_IDLE;

            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            ctl_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            ram_addr_q  <= '0;
            ram_wr_q    <= 1'b0;
            ram_dout_q  <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ctl_q       <= ctl_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            ram_addr_q  <= ram_addr_d;
            ram_wr_q    <= ram_wr_d;
            ram_dout_q  <= ram_dout_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus_if.ram_addr  = ram_addr_q;
    assign bus_if.ram_wr    = ram_wr_q;
    assign bus_if.ram_dout  = ram_dout_q;
    assign bus_if.if_done   = if_done_q;
    assign bus_if.if_data   = if_data_q;
    assign bus_if.mem_done  = mem_done_q;
    assign bus_if.mem_rdata = mem_rdata_q;

    // Stall drops in the done cycle so the pipeline moves on that edge.
    assign bus_if.if_stall_req  = bus_if.if_req & ~if_done_q;
    assign bus_if.mem_stall_req = bus_if.mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: drivers push expected responses computed
// from a byte-array memory model; a negedge monitor checks every done pulse.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    int cyc;
    int n_checks;
    int n_fail;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        bit          chk_data;
        int          due;
    } exp_t;

    exp_t if_q[$];
    exp_t mem_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Addresses used live in 0x000-0xFFF or 0xFFFFF000-0xFFFFFFFF, so this fold is unique.
    function automatic int fold(input logic [31:0] a);
        return int'({a[31], a[11:0]});
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ {a[31:28], a[3:0]} ^ 8'hA5;
    endfunction

    // Physical RAM: read data appears the cycle after its address.
    bit [7:0] ram_arr [8192];
    bit       ram_vld [8192];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_vld[fold(a)] ? ram_arr[fold(a)] : init_byte(a);
    endfunction

    always @(posedge clk) begin
        bus.ram_din <= ram_rd(bus.ram_addr);
        if (bus.ram_wr) begin
            ram_arr[fold(bus.ram_addr)] <= bus.ram_dout;
            ram_vld[fold(bus.ram_addr)] <= 1'b1;
        end
    end

    // Reference memory, updated in program order as requests are issued.
    bit [7:0] ref_arr [8192];
    bit       ref_vld [8192];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_vld[fold(a)] ? ref_arr[fold(a)] : init_byte(a);
    endfunction

    task automatic ref_wr(input logic [31:0] a, input logic [7:0] b);
        ref_arr[fold(a)] = b;
        ref_vld[fold(a)] = 1'b1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Per-cycle trace of the RAM port for cycle-exact directed checks.
    logic [31:0] tr_addr [8192];
    logic        tr_wr   [8192];
    logic [7:0]  tr_dout [8192];

    function automatic int ti(input int c);
        return c & 8191;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        tr_addr[ti(cyc)] <= bus.ram_addr;
        tr_wr[ti(cyc)]   <= bus.ram_wr;
        tr_dout[ti(cyc)] <= bus.ram_dout;
        if (!rst) begin
            if (bus.mem_done) begin
                check("mem_done_expected", 64'(mem_q.size() != 0), 64'd1);
                if (mem_q.size() != 0) begin
                    e = mem_q.pop_front();
                    if (e.due >= 0) check("mem_done_cycle", 64'(cyc), 64'(e.due));
                    if (e.chk_data) check("mem_rdata", 64'(bus.mem_rdata), 64'(e.data));
                end
                check("mem_stall_on_done", 64'(bus.mem_stall_req), 64'd0);
            end else if (bus.mem_req) begin
                check("mem_stall_held", 64'(bus.mem_stall_req), 64'd1);
            end
            if (bus.if_done) begin
                check("if_done_expected", 64'(if_q.size() != 0), 64'd1);
                if (if_q.size() != 0) begin
                    e = if_q.pop_front();
                    if (e.due >= 0) check("if_done_cycle", 64'(cyc), 64'(e.due));
                    check("if_data", 64'(bus.if_data), 64'(e.data));
                end
                check("if_stall_on_done", 64'(bus.if_stall_req), 64'd0);
            end else if (bus.if_req) begin
                check("if_stall_held", 64'(bus.if_stall_req), 64'd1);
            end
        end
    end

    // delay: -1 untimed, 0 standard latency from the issue cycle, >0 explicit.
    task automatic mem_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int delay, input bit sync,
                          output int c0);
        exp_t e;
        int   n;
        bit   seen;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        n = nbytes(size);
        e.data = '0;
        e.chk_data = !we;
        for (int k = 0; k < n; k++) begin
            if (we) ref_wr(addr + 32'(k), wdata[8*k +: 8]);
            else    e.data[8*k +: 8] = ref_rd(addr + 32'(k));
        end
        c0 = cyc;
        if (delay < 0)       e.due = -1;
        else if (delay == 0) e.due = c0 + (we ? n + 1 : n + 2);
        else                 e.due = c0 + delay;
        mem_q.push_back(e);
        bus.mem_we    = we;
        bus.mem_size  = size;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_req   = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_done;
        end
        check("mem_done_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        bus.mem_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input int delay, input bit sync,
                         output int c0);
        exp_t e;
        bit   seen;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        e.data = '0;
        e.chk_data = 1'b1;
        for (int k = 0; k < 4; k++) e.data[8*k +: 8] = ref_rd(addr + 32'(k));
        c0 = cyc;
        if (delay < 0)       e.due = -1;
        else if (delay == 0) e.due = c0 + 6;
        else                 e.due = c0 + delay;
        if_q.push_back(e);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            seen = bus.if_done;
        end
        check("if_done_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    task automatic rand_mem(input int delay);
        logic [31:0] a;
        int          c;
        if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        else                           a = 32'h0000_0400 + 32'($urandom_range(0, 255));
        mem_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, delay, 1'b1, c);
    endtask

    function automatic logic [31:0] rand_fetch_addr();
        return 32'h40 + 32'($urandom_range(0, 32'hB0));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        logic [31:0] wd;

        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.if_flush  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_size  = 2'b00;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_ram_wr",    64'(bus.ram_wr),    64'd0);
        check("rst_ram_addr",  64'(bus.ram_addr),  64'd0);
        check("rst_ram_dout",  64'(bus.ram_dout),  64'd0);
        check("rst_if_done",   64'(bus.if_done),   64'd0);
        check("rst_mem_done",  64'(bus.mem_done),  64'd0);
        check("rst_if_data",   64'(bus.if_data),   64'd0);
        check("rst_mem_rdata", 64'(bus.mem_rdata), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word store then word load at 0x100: bytes 11,22,33,44.
        mem_op(1'b1, 2'b10, 32'h100, 32'h4433_2211, 0, 1'b1, c0);
        mem_op(1'b0, 2'b10, 32'h100, 32'h0, 0, 1'b1, c0);
        for (int k = 0; k < 4; k++) begin
            check("load_word_addr", 64'(tr_addr[ti(c0 + 1 + k)]), 64'(32'h100 + k));
            check("load_word_wr",   64'(tr_wr[ti(c0 + 1 + k)]),   64'd0);
        end

        // Half store 0xBEEF at 0x200; upper wdata bytes must be ignored.
        mem_op(1'b1, 2'b01, 32'h200, 32'h1234_BEEF, 0, 1'b1, c0);
        check("st_half_c1_wr",   64'(tr_wr[ti(c0 + 1)]),   64'd1);
        check("st_half_c1_addr", 64'(tr_addr[ti(c0 + 1)]), 64'h200);
        check("st_half_c1_dout", 64'(tr_dout[ti(c0 + 1)]), 64'hEF);
        check("st_half_c2_wr",   64'(tr_wr[ti(c0 + 2)]),   64'd1);
        check("st_half_c2_addr", 64'(tr_addr[ti(c0 + 2)]), 64'h201);
        check("st_half_c2_dout", 64'(tr_dout[ti(c0 + 2)]), 64'hBE);
        check("st_half_c3_wr",   64'(tr_wr[ti(c0 + 3)]),   64'd0);
        check("st_half_c4_wr",   64'(tr_wr[ti(c0 + 4)]),   64'd0);
        for (int k = 0; k < 3; k++)
            check("st_half_ram", 64'(ram_rd(32'h200 + k)), 64'(ref_rd(32'h200 + k)));

        // Simultaneous requests: MEM word load first, IF granted after mem_done.
        fork
            mem_op(1'b0, 2'b10, 32'h300, 32'h0, 0, 1'b1, c0);
            fetch(32'h60, 13, 1'b1, c1);
        join

        // Fetch at 0x40 flushed in cycle 3; new fetch at 0x80 issued in cycle 4.
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.if_addr = 32'h40;
        bus.if_req  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.if_flush = 1'b1;
        bus.if_req   = 1'b0;
        @(posedge clk);
        #1;
        bus.if_flush = 1'b0;
        check("flush_issue_cycle", 64'(cyc - c0), 64'd4);
        fetch(32'h80, 0, 1'b0, c1);

        // Reset in cycle 2 of a word store: bytes 0 and 1 reach RAM, 2 and 3 do not.
        wd = 32'hA1B2_C3D4;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.mem_we    = 1'b1;
        bus.mem_size  = 2'b10;
        bus.mem_addr  = 32'h208;
        bus.mem_wdata = wd;
        bus.mem_req   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ram_wr",   64'(bus.ram_wr),   64'd0);
        check("rst_mid_ram_addr", 64'(bus.ram_addr), 64'd0);
        check("rst_mid_ram_dout", 64'(bus.ram_dout), 64'd0);
        check("rst_mid_mem_done", 64'(bus.mem_done), 64'd0);
        ref_wr(32'h208, wd[7:0]);
        ref_wr(32'h209, wd[15:8]);
        for (int k = 0; k < 4; k++)
            check("rst_mid_ram", 64'(ram_rd(32'h208 + k)), 64'(ref_rd(32'h208 + k)));
        mem_op(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, c0);

        // Wrap across the top of the address space.
        mem_op(1'b1, 2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 1'b1, c0);
        mem_op(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 0, 1'b1, c0);
        mem_op(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0, 0, 1'b1, c0);

        // Random single-requester traffic with exact latency checks.
        for (int i = 0; i < 25; i++) rand_mem(0);
        for (int i = 0; i < 6; i++) fetch(rand_fetch_addr(), 0, 1'b1, c0);

        // Random overlapping traffic from both requesters.
        fork
            begin
                int cf;
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    fetch(rand_fetch_addr(), -1, 1'b1, cf);
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    rand_mem(-1);
                end
            end
        join

        repeat (5) @(posedge clk);
        check("if_queue_drained",  64'(if_q.size()),  64'd0);
        check("mem_queue_drained", 64'(mem_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM stage. The block serialises 1/2/4-byte accesses into single-byte RAM cycles and assembles the read data little-endian. It raises per-requester stall requests into stall_controller until the access completes. It sits between the pipeline front end / MEM stage and the external RAM.

## Interface
- ADDR_WIDTH, 32, byte address width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; one clock, synchronous, active-high (`RstEnable`)
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_WIDTH  fetch address; always 4 bytes
- if_flush  in  1  abort in-flight fetch (branch redirect)
- if_done  out  1  one-cycle pulse; if_data valid this cycle
- if_data  out  32  fetched instruction
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  32  store data; low bytes used for byte/half
- mem_done  out  1  one-cycle pulse; mem_rdata valid this cycle
- mem_rdata  out  32  load data, zero-extended (sign extension stays in MEM stage)
- if_stall_req  out  1  if_req & ~if_done, combinational
- mem_stall_req  out  1  mem_req & ~mem_done, combinational
- ram_addr  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte; valid the cycle after its address

## Operation
- States: IDLE, ACCESS, DONE. Latched on grant: owner (IF/MEM), we, n (byte count 1/2/4), base address, write data; counter cnt.
- IDLE: mem_req has priority over if_req when both are high. On grant, latch the request fields, set cnt=0 and go to ACCESS. No request: stay in IDLE with ram_wr=0.
- ACCESS, write: each cycle drive ram_addr=base+cnt, ram_wr=1, ram_dout=wdata[8cnt+7:8cnt], then cnt++. After byte n-1, go to DONE.
- ACCESS, read: while cnt<n, drive ram_addr=base+cnt with ram_wr=0. Each cycle with cnt≥1, capture ram_din into byte cnt-1 of the data register. Stay in ACCESS for n+1 cycles, then go to DONE.
- DONE: pulse the owner's done with its registered data, then go to IDLE. New requests are ignored in DONE. The requester drops req the cycle after done.
- Data assembly: byte k of the result is bits [8k+7:8k]; unfilled upper bytes read 0.
- if_flush while IF owns ACCESS: go to IDLE next cycle, no if_done, partial data discarded. if_flush in IDLE or DONE, or while MEM owns the port, has no effect on the port.
- Stores and loads are never aborted.
- Address arithmetic: base+cnt is modulo 2^ADDR_WIDTH; wrap at top of address space is legal. No alignment check.
- Reset, including mid-access: next cycle state=IDLE, cnt=0, ram_wr=0, ram_addr=0, ram_dout=0, if_done=mem_done=0, if_data=mem_rdata=0. The partial access is abandoned. A store may be partially written.

## Timing
- Cycle 0 = the IDLE cycle in which the request is sampled. Address of byte k is driven in cycle 1+k.
- Read: ram_din byte k is sampled in cycle 2+k. Done pulse in cycle n+2: word 6, half 4, byte 3.
- Write: done pulse in cycle n+1: word 5, half 3, byte 2.
- Back-to-back: the earliest next grant is the cycle after DONE, so there is one idle turnaround cycle.
- stall_req falls in the same cycle as done, so stall_controller releases the pipeline on the edge ending the done cycle.
- All outputs except *_stall_req are registered.

## Structure
- defines.v holds:
  - state encodings (`ArbIdle`, `ArbAccess`, `ArbDone`);
  - size encodings (`MemByte`, `MemHalf`, `MemWord`);
  - the owner encoding.
- Single module; no sub-module is required.
- The size→byte-count decode is a local function.

## Test plan
- mem_req load word at 0x100 with RAM bytes 11,22,33,44 → ram_addr 0x100..0x103 in cycles 1-4; mem_done in cycle 6 with mem_rdata=0x44332211.
- mem_req store half 0xBEEF at 0x200 → cycle 1: ram_wr=1, 0x200, dout EF; cycle 2: 0x201, dout BE; mem_done in cycle 3; ram_wr=0 afterwards.
- if_req and mem_req rise in the same cycle → MEM served first; IF granted in the cycle after mem_done; if_stall_req held high throughout.
- IF fetch at 0x40 with if_flush in cycle 3 → IDLE in cycle 4; no if_done; a new if_req at 0x80 returns the correct word.
- rst asserted in cycle 2 of a word store → next cycle ram_wr=0 and state IDLE; a following byte load at 0xFFFFFFFF completes with the correct byte and no wrap errors.
